// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and default byte timeout for the UART transmit arbiter
package uart_arb_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_ACC, WAIT_DONE} state_e;
    localparam int TIMEOUT_CYCLES_DEF = 2_000_000;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or above ptr_i, wrapping
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);
    logic [W-1:0] idx;
    // walk offsets from farthest to nearest so the request closest to ptr_i wins
    always_comb begin
        grant_o = '0;
        any_o = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                grant_o = idx;
                any_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular round-robin sharing of one UART transmitter with stall timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_finish,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_e state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, gid_q, gid_d, pick, sel, nxt;
    logic [7:0] data_q, data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic locked_q, locked_d, last_q, last_d, start_q, start_d, err_q, err_d;
    logic fin_meta_q, fin_s_q, any, take;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req_i  (req_valid),
        .ptr_i  (rr_q),
        .grant_o(pick),
        .any_o  (any)
    );

    assign nxt = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
    assign tx_start = start_q;
    assign tx_data = data_q;
    assign grant_id = gid_q;
    assign busy = state_q != IDLE;
    assign timeout_err = err_q;

    // two-flop synchronizer for the UART status; resets to idle so a fresh start is not mistaken for acceptance
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fin_meta_q <= 1'b1;
            fin_s_q <= 1'b1;
        end else begin
            fin_meta_q <= tx_finish;
            fin_s_q <= fin_meta_q;
        end
    end

    // next-state: grant/fetch a byte, hand it to the UART, track accept/done and abandon stalled bytes
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        gid_d = gid_q;
        data_d = data_q;
        last_d = last_q;
        locked_d = locked_q;
        start_d = start_q;
        err_d = err_q;
        timer_d = timer_q;
        req_ready = '0;
        take = 1'b0;
        sel = gid_q;
        case (state_q)
            IDLE: begin
                sel = pick;
                take = !locked_q && any;
                if (locked_q) state_d = FETCH;
            end
            FETCH: take = req_valid[gid_q];
            START: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT_ACC;
            end
            WAIT_ACC, WAIT_DONE: begin
                timer_d = (timer_q == TW'(TIMEOUT_CYCLES)) ? timer_q : timer_q + 1'b1;
                if (state_q == WAIT_ACC && !fin_s_q) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (state_q == WAIT_DONE && fin_s_q) begin
                    state_d = last_q ? IDLE : FETCH;
                    locked_d = !last_q;
                    rr_d = last_q ? nxt : rr_q;
                end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                    start_d = 1'b0;
                    err_d = 1'b1;
                    locked_d = 1'b0;
                    rr_d = nxt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            req_ready[sel] = 1'b1;
            gid_d = sel;
            data_d = req_data[{sel, 3'b000} +: 8];
            last_d = req_last[sel];
            locked_d = 1'b1;
            state_d = START;
        end
    end

    // state and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q <= '0;
            gid_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            locked_q <= 1'b0;
            start_q <= 1'b0;
            err_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            gid_q <= gid_d;
            data_q <= data_d;
            last_q <= last_d;
            locked_q <= locked_d;
            start_q <= start_d;
            err_q <= err_d;
            timer_q <= timer_d;
        end
    end
endmodule
